// File: rtl/register_file.sv
// MIPS GPR file: DEPTH x DATA_W array with one write port, two registered read ports and a post-reset clear sequencer.
// Optional same-edge write-to-read forwarding is selected with the REGFILE_BYPASS_EN macro.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
    logic              ready_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_a_p0;
    logic [DATA_W-1:0] rd_b_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
            ready   <= ready_nxt;
        end
    end

    // The sequencer owns the array write port until the last entry is cleared.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        ready_nxt   = ready;
        mem_we      = 1'b0;
        mem_addr    = waddr;
        mem_wdata   = wdata;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_idx;
                mem_wdata = '0;
                if (clr_idx == LAST_IDX) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end else begin
                    clr_idx_nxt = clr_idx + ADDR_W'(1);
                end
            end
            RUN: begin
                mem_we = we && (waddr != '0);
            end
            default: begin
                state_nxt = CLEAR;
                ready_nxt = 1'b0;
            end
        endcase
    end

    // Storage has no reset so it can map onto an inferred RAM.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // p0: address decode and optional forwarding of the in-flight write.
    always_comb begin
        rd_a_p0 = mem[raddr_a];
        rd_b_p0 = mem[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (we && (waddr == raddr_a)) rd_a_p0 = wdata;
        if (we && (waddr == raddr_b)) rd_b_p0 = wdata;
`endif
        if (raddr_a == '0) rd_a_p0 = '0;
        if (raddr_b == '0) rd_b_p0 = '0;
    end

    // p1: registered read outputs, forced to zero until the clear completes.
    always_ff @(posedge clk) begin
        if (rst || (state != RUN)) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= rd_a_p0;
            rdata_b <= rd_b_p0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against a behavioural array model, plus literal spot checks.
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              ready;

    int checks = 0;
    int errors = 0;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: contents, clear progress and expected outputs.
    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                m_armed = 1'b0;
    bit                m_ready = 1'b0;
    int                m_clr   = 0;
    logic [DATA_W-1:0] m_a = '0;
    logic [DATA_W-1:0] m_b = '0;

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (BYP && we && (waddr == a)) return wdata;
        return model_mem[a];
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_armed = 1'b1;
            m_ready = 1'b0;
            m_clr   = 0;
            m_a     = '0;
            m_b     = '0;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        end else if (m_armed) begin
            if (!m_ready) begin
                m_clr++;
                if (m_clr == DEPTH) m_ready = 1'b1;
                m_a = '0;
                m_b = '0;
            end else begin
                m_a = model_read(raddr_a);
                m_b = model_read(raddr_b);
                if (we && (waddr != 0)) model_mem[waddr] = wdata;
            end
        end
        #1;
        if (m_armed) begin
            chk("cyc_ready", {31'b0, ready}, {31'b0, m_ready});
            chk("cyc_rdata_a", rdata_a, m_a);
            chk("cyc_rdata_b", rdata_b, m_b);
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra,
                       input logic [ADDR_W-1:0] rb);
        rst = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        @(posedge clk);
        #2;
    endtask

    // Drops rst and counts edges until ready, with a bounded wait.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            cyc(1'b0, (n == 5), 5'd3, 32'd7, 5'($urandom), 5'($urandom));
            n++;
        end
        chk(name, 32'(n), 32'd32);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        cyc(1'b1, 1'b0, 0, 0, 0, 0);
        cyc(1'b1, 1'b0, 0, 0, 0, 0);
        chk("reset_ready", {31'b0, ready}, 32'd0);
        chk("reset_rdata_a", rdata_a, 32'd0);
        wait_ready("clear_edges");

        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 0, 0, 5'(i), 5'(DEPTH - 1 - i));

        cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 0, 0);
        cyc(1'b0, 1'b0, 0, 0, 5'd5, 5'd5);
        chk("r5_a", rdata_a, 32'hDEADBEEF);
        chk("r5_b", rdata_b, 32'hDEADBEEF);

        cyc(1'b0, 1'b1, 5'd0, 32'h12345678, 0, 0);
        cyc(1'b0, 1'b0, 0, 0, 5'd0, 5'd3);
        chk("r0_zero", rdata_a, 32'd0);
        chk("r3_clear_write_ignored", rdata_b, 32'd0);

        cyc(1'b0, 1'b1, 5'd9, 32'h1, 0, 0);
        cyc(1'b0, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
        chk("rdw_r9", rdata_a, BYP ? 32'h2 : 32'h1);
        cyc(1'b0, 1'b0, 0, 0, 5'd9, 5'd0);
        chk("r9_after", rdata_a, 32'h2);

        for (int i = 0; i < 400; i++) begin
            logic [ADDR_W-1:0] wa;
            wa = 5'($urandom);
            cyc(1'b0, 1'($urandom), wa, $urandom,
                ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
        end

        for (int i = 1; i < DEPTH; i++) cyc(1'b0, 1'b1, 5'(i), 32'(i), 0, 0);
        cyc(1'b0, 1'b0, 0, 0, 5'd1, 5'd31);
        chk("pair_r1", rdata_a, 32'd1);
        chk("pair_r31", rdata_b, 32'd31);
        cyc(1'b0, 1'b0, 0, 0, 5'd16, 5'd17);
        chk("pair_r16", rdata_a, 32'd16);
        chk("pair_r17", rdata_b, 32'd17);

        cyc(1'b1, 1'b1, 5'd4, 32'hABCD, 5'd31, 5'd1);
        chk("rerst_ready", {31'b0, ready}, 32'd0);
        wait_ready("reclear_edges");
        cyc(1'b0, 1'b0, 0, 0, 5'd31, 5'd4);
        chk("r31_cleared", rdata_a, 32'd0);
        chk("r4_cleared", rdata_b, 32'd0);

        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 5'(i), $urandom, 5'(i), 5'(i));
        cyc(1'b1, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) cyc(1'b0, 1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
